// File: rtl/bus_arbiter.sv
// Two-manager front end for system_bus: serialises manager 0 / manager 1 transactions,
// hides the bus idle-default responses from non-owners and aborts hung transfers.
module bus_arbiter #(
    parameter int ARBITRATION    = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] m0_rw_address,
    output logic [31:0] m0_read_data,
    input  logic        m0_read_request,
    output logic        m0_read_response,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_write_strobe,
    input  logic        m0_write_request,
    output logic        m0_write_response,
    input  logic [31:0] m1_rw_address,
    output logic [31:0] m1_read_data,
    input  logic        m1_read_request,
    output logic        m1_read_response,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_write_strobe,
    input  logic        m1_write_request,
    output logic        m1_write_response,
    output logic [31:0] bus_rw_address,
    input  logic [31:0] bus_read_data,
    output logic        bus_read_request,
    input  logic        bus_read_response,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_write_strobe,
    output logic        bus_write_request,
    input  logic        bus_write_response,
    output logic        timeout_error
);
    localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
    localparam logic OWN_M0 = 1'b0, OWN_M1 = 1'b1;
    localparam bit WDOG_EN = TIMEOUT_CYCLES != 0;
    localparam int CW = WDOG_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic          owner_q, owner_d;
    logic          op_wr_q, op_wr_d;
    logic          last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        m0_req, m1_req, win, win_wr, own_req, done, expire;
    logic        rsp_rd, rsp_wr;
    logic [31:0] rsp_data;

    assign m0_req  = m0_read_request | m0_write_request;
    assign m1_req  = m1_read_request | m1_write_request;
    assign own_req = (owner_q == OWN_M1) ? m1_req : m0_req;
    assign done    = op_wr_q ? bus_write_response : bus_read_response;
    assign expire  = WDOG_EN && (cnt_q == CNT_LAST) && !done;

    always_comb begin
        win = OWN_M0;
        if (m0_req && m1_req)
            win = (ARBITRATION == 1) ? OWN_M0 : ~last_q;
        else if (m1_req)
            win = OWN_M1;
    end

    // A request with both read and write high is taken as a read.
    assign win_wr = (win == OWN_M1) ? (m1_write_request & ~m1_read_request)
                                    : (m0_write_request & ~m0_read_request);

    assign bus_rw_address   = (owner_q == OWN_M1) ? m1_rw_address   : m0_rw_address;
    assign bus_write_data   = (owner_q == OWN_M1) ? m1_write_data   : m0_write_data;
    assign bus_write_strobe = (owner_q == OWN_M1) ? m1_write_strobe : m0_write_strobe;

    always_comb begin
        state_d           = state_q;
        owner_d           = owner_q;
        op_wr_d           = op_wr_q;
        last_d            = last_q;
        cnt_d             = cnt_q;
        bus_read_request  = 1'b0;
        bus_write_request = 1'b0;
        timeout_error     = 1'b0;
        rsp_rd            = 1'b0;
        rsp_wr            = 1'b0;
        rsp_data          = '0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_d = win;
                    op_wr_d = win_wr;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                // Bus responses here are its idle default and carry no meaning.
                bus_read_request  = ~op_wr_q;
                bus_write_request = op_wr_q;
                state_d           = WAIT;
            end
            WAIT: begin
                bus_read_request  = ~op_wr_q;
                bus_write_request = op_wr_q;
                if (done || expire) begin
                    // An owner that already dropped its request gets nothing.
                    rsp_rd        = ~op_wr_q & own_req;
                    rsp_wr        = op_wr_q & own_req;
                    rsp_data      = (done && !op_wr_q && own_req) ? bus_read_data : '0;
                    timeout_error = expire;
                    last_d        = owner_q;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else if (WDOG_EN) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (reset) begin
            bus_read_request  = 1'b0;
            bus_write_request = 1'b0;
            timeout_error     = 1'b0;
            rsp_rd            = 1'b0;
            rsp_wr            = 1'b0;
            rsp_data          = '0;
        end
    end

    assign m0_read_response  = rsp_rd & (owner_q == OWN_M0);
    assign m0_write_response = rsp_wr & (owner_q == OWN_M0);
    assign m0_read_data      = (owner_q == OWN_M0) ? rsp_data : '0;
    assign m1_read_response  = rsp_rd & (owner_q == OWN_M1);
    assign m1_write_response = rsp_wr & (owner_q == OWN_M1);
    assign m1_read_data      = (owner_q == OWN_M1) ? rsp_data : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= OWN_M0;
            op_wr_q <= 1'b0;
            last_q  <= OWN_M1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            op_wr_q <= op_wr_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Random-traffic bench for bus_arbiter: u0 is round-robin with a 16-cycle watchdog,
// u1 is fixed-priority with a 4-cycle watchdog; a transaction-level model predicts every output.
module tb_bus_arbiter;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rst     [2];
    logic [31:0] m_addr  [2][2];
    logic [31:0] m_wd    [2][2];
    logic [3:0]  m_strb  [2][2];
    logic        m_rd    [2][2];
    logic        m_wr    [2][2];
    logic [31:0] m_rdat  [2][2];
    logic        m_rresp [2][2];
    logic        m_wresp [2][2];
    logic [31:0] b_addr  [2];
    logic [31:0] b_rdat  [2];
    logic        b_rreq  [2];
    logic        b_rrsp  [2];
    logic [31:0] b_wd    [2];
    logic [3:0]  b_strb  [2];
    logic        b_wreq  [2];
    logic        b_wrsp  [2];
    logic        tout    [2];

    for (genvar k = 0; k < 2; k++) begin : g
        bus_arbiter #(.ARBITRATION(k), .TIMEOUT_CYCLES(k == 1 ? 4 : 16)) u (
            .clock(clock), .reset(rst[k]),
            .m0_rw_address(m_addr[k][0]), .m0_read_data(m_rdat[k][0]),
            .m0_read_request(m_rd[k][0]), .m0_read_response(m_rresp[k][0]),
            .m0_write_data(m_wd[k][0]), .m0_write_strobe(m_strb[k][0]),
            .m0_write_request(m_wr[k][0]), .m0_write_response(m_wresp[k][0]),
            .m1_rw_address(m_addr[k][1]), .m1_read_data(m_rdat[k][1]),
            .m1_read_request(m_rd[k][1]), .m1_read_response(m_rresp[k][1]),
            .m1_write_data(m_wd[k][1]), .m1_write_strobe(m_strb[k][1]),
            .m1_write_request(m_wr[k][1]), .m1_write_response(m_wresp[k][1]),
            .bus_rw_address(b_addr[k]), .bus_read_data(b_rdat[k]),
            .bus_read_request(b_rreq[k]), .bus_read_response(b_rrsp[k]),
            .bus_write_data(b_wd[k]), .bus_write_strobe(b_strb[k]),
            .bus_write_request(b_wreq[k]), .bus_write_response(b_wrsp[k]),
            .timeout_error(tout[k])
        );
    end

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad < 60) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // reference model: one in-flight transaction per arbiter, tracked by its age since grant
    bit busy [2];
    bit own  [2];
    bit opw  [2];
    bit last [2];
    int age  [2];
    int n_to [2], n_done [2], n_tie [2];
    bit gotr [2][2];
    int cool [2][2];
    int dage [2], dlat [2];

    task automatic new_txn(input int k, input int m);
        int sel;
        sel = int'($urandom % 16);
        m_addr[k][m] = $urandom;
        m_wd[k][m]   = $urandom;
        m_strb[k][m] = (m == 1 && $urandom % 2 == 0) ? 4'b0011 : 4'($urandom);
        m_rd[k][m]   = (sel < 8);
        m_wr[k][m]   = (sel == 0) || (sel >= 8);
    endtask

    task automatic drive(input int k, input int cyc);
        bit pend;
        rst[k] = (cyc < 3) || ($urandom % 150 == 0);
        for (int m = 0; m < 2; m++) begin
            if (cool[k][m] > 0) cool[k][m]--;
            pend = m_rd[k][m] | m_wr[k][m];
            if (gotr[k][m]) begin
                gotr[k][m] = 0;
                m_rd[k][m] = 0;
                m_wr[k][m] = 0;
                if ($urandom % 2 == 0) new_txn(k, m);
            end else if (pend && $urandom % 60 == 0) begin
                m_rd[k][m] = 0;
                m_wr[k][m] = 0;
                cool[k][m] = 40;
            end else if (!pend && cool[k][m] == 0 && $urandom % 3 == 0) begin
                new_txn(k, m);
            end
        end
    endtask

    // system_bus stand-in: idle default of 1, then the matching response after a random delay
    task automatic device(input int k);
        bit hit;
        b_rdat[k] = $urandom;
        if (!(b_rreq[k] || b_wreq[k])) begin
            b_rrsp[k] = 1;
            b_wrsp[k] = 1;
            dage[k]   = 0;
        end else if (dage[k] == 0) begin
            b_rrsp[k] = 1;
            b_wrsp[k] = 1;
            dlat[k]   = ($urandom % 4 == 0) ? int'($urandom % 25) : int'($urandom % 4);
            dage[k]   = 1;
        end else begin
            hit = (dage[k] - 1 == dlat[k]);
            if (b_rreq[k]) begin
                b_rrsp[k] = hit;
                b_wrsp[k] = 1'($urandom);
            end else begin
                b_wrsp[k] = hit;
                b_rrsp[k] = 1'($urandom);
            end
            dage[k]++;
        end
    endtask

    task automatic model_step(input int k);
        bit er [2], ew [2], req [2];
        logic [31:0] ed [2];
        bit ebr, ebw, eto, act, dn, to;
        int w, tmo;
        for (int m = 0; m < 2; m++) begin
            req[m] = m_rd[k][m] | m_wr[k][m];
            er[m] = 0; ew[m] = 0; ed[m] = '0;
        end
        ebr = 0; ebw = 0; eto = 0;
        act = busy[k] && !rst[k];
        tmo = (k == 1) ? 4 : 16;
        if (rst[k]) begin
            busy[k] = 0;
            last[k] = 1;
        end else if (!busy[k]) begin
            if (req[0] || req[1]) begin
                if (req[0] && req[1]) begin
                    n_tie[k]++;
                    w = (k == 1) ? 0 : (last[k] ? 0 : 1);
                end else begin
                    w = req[1] ? 1 : 0;
                end
                own[k]  = w[0];
                opw[k]  = m_wr[k][w] && !m_rd[k][w];
                busy[k] = 1;
                age[k]  = 0;
            end
        end else begin
            ebr = !opw[k];
            ebw = opw[k];
            if (age[k] == 0) begin
                age[k] = 1;
            end else begin
                dn = opw[k] ? b_wrsp[k] : b_rrsp[k];
                to = (age[k] == tmo) && !dn;
                if (dn || to) begin
                    w = int'(own[k]);
                    if (req[w]) begin
                        if (opw[k]) ew[w] = 1;
                        else begin
                            er[w] = 1;
                            if (dn) ed[w] = b_rdat[k];
                        end
                    end
                    eto     = to;
                    busy[k] = 0;
                    last[k] = own[k];
                    if (to) n_to[k]++; else n_done[k]++;
                end else begin
                    age[k]++;
                end
            end
        end
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("u%0d.m%0d_read_response", k, m), 32'(m_rresp[k][m]), 32'(er[m]));
            chk($sformatf("u%0d.m%0d_write_response", k, m), 32'(m_wresp[k][m]), 32'(ew[m]));
            chk($sformatf("u%0d.m%0d_read_data", k, m), m_rdat[k][m], ed[m]);
            gotr[k][m] = er[m] | ew[m];
        end
        chk($sformatf("u%0d.bus_read_request", k), 32'(b_rreq[k]), 32'(ebr));
        chk($sformatf("u%0d.bus_write_request", k), 32'(b_wreq[k]), 32'(ebw));
        chk($sformatf("u%0d.timeout_error", k), 32'(tout[k]), 32'(eto));
        if (act) begin
            chk($sformatf("u%0d.bus_rw_address", k), b_addr[k], m_addr[k][own[k]]);
            chk($sformatf("u%0d.bus_write_data", k), b_wd[k], m_wd[k][own[k]]);
            chk($sformatf("u%0d.bus_write_strobe", k), 32'(b_strb[k]), 32'(m_strb[k][own[k]]));
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1; busy[k] = 0; last[k] = 1; age[k] = 0;
            n_to[k] = 0; n_done[k] = 0; n_tie[k] = 0; dage[k] = 0; dlat[k] = 0;
            b_rdat[k] = '0; b_rrsp[k] = 1; b_wrsp[k] = 1;
            for (int m = 0; m < 2; m++) begin
                m_addr[k][m] = '0; m_wd[k][m] = '0; m_strb[k][m] = '0;
                m_rd[k][m] = 0; m_wr[k][m] = 0; gotr[k][m] = 0; cool[k][m] = 0;
            end
        end
        for (int cyc = 0; cyc < 5000; cyc++) begin
            @(posedge clock);
            #1;
            for (int k = 0; k < 2; k++) drive(k, cyc);
            #1;
            for (int k = 0; k < 2; k++) device(k);
            @(negedge clock);
            for (int k = 0; k < 2; k++) model_step(k);
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.saw_timeout", k), 32'(n_to[k] > 0), 32'd1);
            chk($sformatf("u%0d.saw_completion", k), 32'(n_done[k] > 0), 32'd1);
            chk($sformatf("u%0d.saw_tie", k), 32'(n_tie[k] > 0), 32'd1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
